// File: rtl/mult_seq_ctrl.sv
// Memory-mapped sequencer for a shared combinational array multiplier.
// A 4-word register window on the CPU look-ahead bus loads the operands and
// starts an operation. The FSM then waits for the ripple to settle and
// captures the product into RESULT.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | operands writable, waiting for START (or OPB write in AUTO)
//   S_SETTLE  | operands frozen, down-counter lets the multiplier settle
//   S_CAPTURE | product latched into RESULT, DONE set, done_irq follows
module mult_seq_ctrl #(
  parameter int unsigned N             = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0FFF_FFF0,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           mem_la_read,
  input  logic           mem_la_write,
  input  logic [31:0]    mem_la_addr,
  input  logic [31:0]    mem_la_wdata,
  input  logic [3:0]     mem_la_wstrb,
  output logic           rd_hit,
  output logic [31:0]    rd_data,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_p,
  output logic           busy,
  output logic           done_irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    settle_cnt;
  logic [N-1:0]  opa_q;
  logic [N-1:0]  opb_q;
  logic [31:0]   result_q;
  logic          auto_q;
  logic          done_q;
  logic          ovr_q;

  logic          win_hit;
  logic [1:0]    win_off;
  logic          wr_opa, wr_opb, wr_ctrl, rd_result;
  logic          ctrl_start, ctrl_clr;
  logic          is_idle, trigger, ovr_set, capture;
  logic          unused_wstrb;

  // Only operand bytes 0 and 1 are ever writable; upper strobes have no target.
  assign unused_wstrb = ^mem_la_wstrb[3:2];

  // Window decode: word-aligned accesses inside the 16-byte window only.
  assign win_hit   = (mem_la_addr[31:4] == BASE_ADDR[31:4]) && (mem_la_addr[1:0] == 2'b00);
  assign win_off   = mem_la_addr[3:2];
  assign wr_opa    = mem_la_write && win_hit && (win_off == 2'd0);
  assign wr_opb    = mem_la_write && win_hit && (win_off == 2'd1);
  assign wr_ctrl   = mem_la_write && win_hit && (win_off == 2'd3) && mem_la_wstrb[0];
  assign rd_result = mem_la_read  && win_hit && (win_off == 2'd2);

  assign ctrl_start = wr_ctrl && mem_la_wdata[0];
  assign ctrl_clr   = wr_ctrl && mem_la_wdata[2];

  assign is_idle = (state == S_IDLE);
  assign capture = (state == S_CAPTURE);
  assign trigger = is_idle && (ctrl_start || (wr_opb && auto_q));
  assign ovr_set = !is_idle && (wr_opa || wr_opb || ctrl_start);

  assign mul_a = opa_q;
  assign mul_b = opb_q;

  // Merge the low two bytes of write data into an operand under byte strobes.
  function automatic logic [N-1:0] merge_lo(input logic [N-1:0] cur,
                                            input logic [31:0]  wd,
                                            input logic [3:0]   ws);
    logic [31:0] mask;
    logic [31:0] merged;
    mask   = {16'h0000, {8{ws[1]}}, {8{ws[0]}}};
    merged = (32'(cur) & ~mask) | (wd & mask);
    return merged[N-1:0];
  endfunction

  // Operand registers: writable only in IDLE so the multiplier inputs stay frozen.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (is_idle) begin
      if (wr_opa) opa_q <= merge_lo(opa_q, mem_la_wdata, mem_la_wstrb);
      if (wr_opb) opb_q <= merge_lo(opb_q, mem_la_wdata, mem_la_wstrb);
    end
  end

  // Sequencer: settle countdown, product capture, busy and completion pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      result_q   <= '0;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
    end else begin
      done_irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state      <= S_SETTLE;
            settle_cnt <= 8'(SETTLE_CYCLES - 1);
            busy       <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) state <= S_CAPTURE;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        S_CAPTURE: begin
          result_q <= 32'(mul_p);
          done_irq <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Status bits: later assignments win, so CLR beats an OVR set and CAPTURE beats a clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      auto_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_ctrl) auto_q <= mem_la_wdata[1];
      if (ovr_set)  ovr_q <= 1'b1;
      if (ctrl_clr) ovr_q <= 1'b0;
      if (ctrl_clr || rd_result) done_q <= 1'b0;
      if (capture) done_q <= 1'b1;
    end
  end

  // Registered read port: data for a window read appears the following cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_hit  <= mem_la_read && win_hit;
      rd_data <= '0;
      if (mem_la_read && win_hit) begin
        case (win_off)
          2'd0:    rd_data <= 32'(opa_q);
          2'd1:    rd_data <= 32'(opb_q);
          2'd2:    rd_data <= result_q;
          default: rd_data <= {28'd0, auto_q, ovr_q, done_q, busy};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: table of multiply vectors plus
// hand-written sequences for AUTO start, overrun, reset abort and the
// RESULT-read-during-capture race.
module tb_mult_seq_ctrl;

  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0FFF_FFF0;
  localparam int          SC   = 4;
  localparam logic [31:0] OFF_OPA  = 32'h0;
  localparam logic [31:0] OFF_OPB  = 32'h4;
  localparam logic [31:0] OFF_RES  = 32'h8;
  localparam logic [31:0] OFF_CTRL = 32'hC;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           mem_la_read = 1'b0;
  logic           mem_la_write = 1'b0;
  logic [31:0]    mem_la_addr = '0;
  logic [31:0]    mem_la_wdata = '0;
  logic [3:0]     mem_la_wstrb = '0;
  logic           rd_hit;
  logic [31:0]    rd_data;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [2*N-1:0] mul_p;
  logic           busy;
  logic           done_irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] opa_w;
    logic [31:0] opb_w;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs [6];

  mult_seq_ctrl #(.N(N), .BASE_ADDR(BASE), .SETTLE_CYCLES(SC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_la_read  (mem_la_read),
    .mem_la_write (mem_la_write),
    .mem_la_addr  (mem_la_addr),
    .mem_la_wdata (mem_la_wdata),
    .mem_la_wstrb (mem_la_wstrb),
    .rd_hit       (rd_hit),
    .rd_data      (rd_data),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_p        (mul_p),
    .busy         (busy),
    .done_irq     (done_irq)
  );

  // External combinational array multiplier.
  assign mul_p = 32'(mul_a) * 32'(mul_b);

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    mem_la_addr  = BASE + off;
    mem_la_wdata = d;
    mem_la_wstrb = s;
    mem_la_write = 1'b1;
    @(posedge clk);
    #1;
    mem_la_write = 1'b0;
    mem_la_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic hit, output logic [31:0] d);
    @(negedge clk);
    mem_la_addr = addr;
    mem_la_read = 1'b1;
    @(posedge clk);
    #1;
    hit = rd_hit;
    d   = rd_data;
    mem_la_read = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic        h;
    logic [31:0] d;
    rd(BASE + off, h, d);
    chk({name, "_hit"}, 32'(h), 32'd1);
    chk(name, d, exp);
  endtask

  // Watch 12 cycles after a trigger: busy cycles, irq pulses, first irq index.
  task automatic observe(output int bc, output int ic, output int idx);
    bc = 0; ic = 0; idx = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done_irq) begin
        ic++;
        if (idx < 0) idx = i;
      end
    end
  endtask

  task automatic wait_irq(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_irq) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int          bc, ic, idx;
    logic        h;
    logic [31:0] d;

    vecs[0] = '{opa_w: 32'h0000_0003, opb_w: 32'h0000_0005, exp_res: 32'h0000_000F};
    vecs[1] = '{opa_w: 32'h0000_FFFF, opb_w: 32'h0000_FFFF, exp_res: 32'hFFFE_0001};
    vecs[2] = '{opa_w: 32'hDEAD_1234, opb_w: 32'hBEEF_5678, exp_res: 32'h0626_0060};
    vecs[3] = '{opa_w: 32'h0000_0000, opb_w: 32'h0000_1234, exp_res: 32'h0000_0000};
    vecs[4] = '{opa_w: 32'h0000_0001, opb_w: 32'h0000_FFFF, exp_res: 32'h0000_FFFF};
    vecs[5] = '{opa_w: 32'h0000_0100, opb_w: 32'h0000_0100, exp_res: 32'h0001_0000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done_irq", 32'(done_irq), 32'd0);
    chk("rst_rd_hit",   32'(rd_hit),   32'd0);
    chk("rst_rd_data",  rd_data,       32'd0);
    chk("rst_mul_a",    32'(mul_a),    32'd0);
    chk("rst_mul_b",    32'(mul_b),    32'd0);
    resetn = 1'b1;
    rd_chk("rst_status", OFF_CTRL, 32'h0);

    // Table-driven multiplies through START
    for (int i = 0; i < 6; i++) begin
      wr(OFF_OPA, vecs[i].opa_w, 4'hF);
      wr(OFF_OPB, vecs[i].opb_w, 4'hF);
      wr(OFF_CTRL, 32'h1, 4'hF);
      observe(bc, ic, idx);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(SC + 1));
      chk($sformatf("v%0d_irq_count", i), 32'(ic), 32'd1);
      chk($sformatf("v%0d_irq_index", i), 32'(idx), 32'(SC + 1));
      rd_chk($sformatf("v%0d_status_done", i), OFF_CTRL, 32'h2);
      rd_chk($sformatf("v%0d_result", i), OFF_RES, vecs[i].exp_res);
      rd_chk($sformatf("v%0d_status_clr", i), OFF_CTRL, 32'h0);
    end

    // Byte strobes on operands
    wr(OFF_OPA, 32'h0000_FFFF, 4'hF);
    wr(OFF_OPA, 32'h0000_0012, 4'b0001);
    rd_chk("strb_b0", OFF_OPA, 32'h0000_FF12);
    wr(OFF_OPA, 32'hABCD_3400, 4'b0010);
    rd_chk("strb_b1", OFF_OPA, 32'h0000_3412);
    wr(OFF_OPB, 32'h5555_5555, 4'b1100);
    rd_chk("strb_hi_only", OFF_OPB, 32'h0000_0100);

    // Addresses outside the window
    rd(BASE + 32'h10, h, d);
    chk("miss_above_hit", 32'(h), 32'd0);
    rd(BASE - 32'h4, h, d);
    chk("miss_below_hit", 32'(h), 32'd0);
    wr(32'h10, 32'h1, 4'hF);
    @(negedge clk);
    chk("miss_no_start", 32'(busy), 32'd0);

    // AUTO: OPB write starts the operation
    wr(OFF_CTRL, 32'h2, 4'hF);
    rd_chk("auto_status", OFF_CTRL, 32'h8);
    wr(OFF_OPA, 32'd7, 4'hF);
    @(negedge clk);
    chk("auto_opa_no_start", 32'(busy), 32'd0);
    wr(OFF_OPB, 32'd9, 4'hF);
    observe(bc, ic, idx);
    chk("auto_busy_cycles", 32'(bc), 32'(SC + 1));
    chk("auto_irq_count", 32'(ic), 32'd1);
    rd_chk("auto_result", OFF_RES, 32'd63);
    wr(OFF_CTRL, 32'h0, 4'hF);
    rd_chk("auto_off_status", OFF_CTRL, 32'h0);

    // Overrun: operand write and START while busy are dropped
    wr(OFF_OPA, 32'd2, 4'hF);
    wr(OFF_OPB, 32'd3, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'hF);
    wr(OFF_OPA, 32'd1, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'hF);
    rd_chk("ovr_status_busy", OFF_CTRL, 32'h5);
    wait_irq("ovr_irq_seen");
    rd_chk("ovr_opa_kept", OFF_OPA, 32'd2);
    rd_chk("ovr_result", OFF_RES, 32'd6);
    rd_chk("ovr_status_sticky", OFF_CTRL, 32'h4);
    wr(OFF_CTRL, 32'h4, 4'hF);
    rd_chk("ovr_status_clr", OFF_CTRL, 32'h0);

    // CLR beats an OVR set in the same write
    wr(OFF_CTRL, 32'h1, 4'hF);
    wr(OFF_CTRL, 32'h5, 4'hF);
    rd_chk("clr_prio_status", OFF_CTRL, 32'h1);
    wait_irq("clr_prio_irq_seen");
    rd_chk("clr_prio_result", OFF_RES, 32'd6);

    // Reset mid-SETTLE aborts with no capture
    wr(OFF_OPA, 32'd4, 4'hF);
    wr(OFF_OPB, 32'd5, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'hF);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mul_a", 32'(mul_a), 32'd0);
    chk("abort_mul_b", 32'(mul_b), 32'd0);
    observe(bc, ic, idx);
    chk("abort_irq_count", 32'(ic), 32'd0);
    chk("abort_busy_cycles", 32'(bc), 32'd0);
    rd_chk("abort_opa", OFF_OPA, 32'h0);
    rd_chk("abort_opb", OFF_OPB, 32'h0);
    rd_chk("abort_result", OFF_RES, 32'h0);
    rd_chk("abort_status", OFF_CTRL, 32'h0);

    // RESULT read lands in the CAPTURE cycle
    wr(OFF_OPA, 32'd6, 4'hF);
    wr(OFF_OPB, 32'd7, 4'hF);
    wr(OFF_CTRL, 32'h1, 4'hF);
    repeat (SC) @(posedge clk);
    rd(BASE + OFF_RES, h, d);
    chk("race_hit", 32'(h), 32'd1);
    chk("race_old_result", d, 32'h0);
    rd_chk("race_status_done", OFF_CTRL, 32'h2);
    rd_chk("race_new_result", OFF_RES, 32'd42);
    rd_chk("race_status_clr", OFF_CTRL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, operand width of the shared array multiplier.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0FFF_FFF0, word-aligned base of a 4-word register window.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, ripple-settle cycles allowed before product capture; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have ports mem_la_read / mem_la_write, input, 1 each: CPU look-ahead read/write strobes.
REQ-007 SHALL have ports mem_la_addr, input, 32, and mem_la_wdata, input, 32: look-ahead address and write data.
REQ-008 SHALL have port mem_la_wstrb, input, 4: byte write strobes.
REQ-009 SHALL have port rd_hit, output, 1: registered flag, rd_data valid for a window read issued the previous cycle.
REQ-010 SHALL have port rd_data, output, 32: registered read data.
REQ-011 SHALL have ports mul_a / mul_b, output, N each: operands to the combinational multiplier.
REQ-012 SHALL have port mul_p, input, 2N: multiplier product.
REQ-013 SHALL have port busy, output, 1, and port done_irq, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL decode offsets: +0 OPA (W/R), +4 OPB (W/R), +8 RESULT (R), +C CTRL/STATUS (W/R); other addresses ignored, rd_hit stays 0.
REQ-015 SHALL update OPA/OPB bytes 0 and 1 only under wstrb[0]/wstrb[1]; wdata[31:N] ignored.
REQ-016 SHALL decode CTRL write bits: bit0 START, bit1 AUTO (stored), bit2 CLR (clears DONE and OVR).
REQ-017 SHALL read STATUS as {28'b0, AUTO, OVR, DONE, BUSY}; OPA/OPB read zero-extended.
REQ-018 SHALL present read data one cycle after mem_la_read: rd_hit=1 and rd_data valid in cycle T+1.
REQ-019 SHALL implement FSM IDLE -> SETTLE -> CAPTURE -> IDLE.
REQ-020 SHALL leave IDLE on a START write, or on an OPB write when AUTO=1; the OPB value written in that cycle is the one used.
REQ-021 SHALL drive mul_a=OPA, mul_b=OPB continuously; operands are frozen outside IDLE.
REQ-022 SHALL hold SETTLE exactly SETTLE_CYCLES cycles via a down-counter, then go to CAPTURE for one cycle.
REQ-023 SHALL in CAPTURE latch mul_p into RESULT (zero-extended to 32), set DONE, pulse done_irq.
REQ-024 SHALL assert busy in SETTLE and CAPTURE; trigger in cycle T gives DONE=1 at T+SETTLE_CYCLES+2.
REQ-025 SHALL ignore OPA/OPB writes and START while busy, and set sticky OVR; AUTO and CLR are still honoured.
REQ-026 SHALL clear DONE on a RESULT read, except when CAPTURE occurs the same cycle: DONE stays set, read returns the old RESULT.
REQ-027 SHALL give CLR priority over an OVR set in the same cycle, but not over a CAPTURE DONE set.

Reset
REQ-028 SHALL, while resetn=0 at a clock edge, force state IDLE, counter 0, OPA=OPB=RESULT=0, AUTO=DONE=OVR=0, busy=0, done_irq=0, rd_hit=0, rd_data=0.
REQ-029 SHALL abort an in-flight operation on reset, with no capture and no done_irq.

Verification
REQ-030 SHALL verify: OPA=3, OPB=5, START -> busy for 5 cycles, done_irq once, RESULT reads 32'h0000_000F, DONE then 0.
REQ-031 SHALL verify: OPA=OPB=16'hFFFF -> RESULT 32'hFFFE_0001.
REQ-032 SHALL verify: AUTO=1, OPA=7, write OPB=9 -> operation starts with no START write, RESULT=63.
REQ-033 SHALL verify: during SETTLE, OPA=1 write and START -> ignored, STATUS OVR=1, RESULT matches the original operands; CLR -> OVR=0.
REQ-034 SHALL verify: resetn=0 for one cycle mid-SETTLE -> no done_irq, all registers 0, busy=0 next cycle.
REQ-035 SHALL verify: RESULT read in the CAPTURE cycle -> old value returned, DONE=1 afterwards.
